// File: rtl/pipe_skid_regs_pkg.sv
// Shared definitions for the pipe_skid_regs elastic register stage.
// The optional stall counter is enabled by defining PIPE_SKID_PERF_EN.
package pipe_skid_regs_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    localparam int DEFAULT_LANES = 4;
    localparam int DEFAULT_WIDTH = 64;
    localparam int STALL_CNT_W   = 32;

    // MAIN is occupied, and therefore presented downstream, in ONE and TWO.
    function automatic logic main_occupied(skid_state_e s);
        return (s == ST_ONE) || (s == ST_TWO);
    endfunction

endpackage

// File: rtl/pipe_skid_regs_if.sv
// Bundle handshake bundle for pipe_skid_regs: upstream push side, downstream pop side, flush.
interface pipe_skid_regs_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 64
);
    logic                   clear;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES-1:0]       in_lane_valid;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES-1:0]       out_lane_valid;
    logic [LANES*WIDTH-1:0] out_data;

    modport master (
        output clear, in_valid, in_lane_valid, in_data, out_ready,
        input  in_ready, out_valid, out_lane_valid, out_data
    );

    modport slave (
        input  clear, in_valid, in_lane_valid, in_data, out_ready,
        output in_ready, out_valid, out_lane_valid, out_data
    );
endinterface

// File: rtl/pipe_skid_entry.sv
// One bundle register (lane-valid + payload) with load and clear; clear only zeroes lane-valid.
module pipe_skid_entry #(
    parameter int LANES = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   load,
    input  logic [LANES-1:0]       lane_valid_d,
    input  logic [LANES*WIDTH-1:0] data_d,
    output logic [LANES-1:0]       lane_valid_q,
    output logic [LANES*WIDTH-1:0] data_q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            lane_valid_q <= '0;
            data_q       <= '0;
        end else if (clear) begin
            lane_valid_q <= '0;
        end else if (load) begin
            lane_valid_q <= lane_valid_d;
            data_q       <= data_d;
        end
    end

endmodule

// File: rtl/pipe_skid_regs.sv
// Two-entry elastic register (MAIN + SKID) for multi-lane bundles with registered in_ready.
// Define PIPE_SKID_PERF_EN to add the stall_cycles performance counter output.
//
// state    | meaning
// ST_EMPTY | no bundle held, out_valid low
// ST_ONE   | MAIN holds the presented bundle
// ST_TWO   | MAIN presented, SKID holds the next bundle, in_ready low
module pipe_skid_regs
    import pipe_skid_regs_pkg::*;
#(
    parameter int LANES = DEFAULT_LANES,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    pipe_skid_regs_if.slave        bus
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

    skid_state_e            state_q, state_d;
    logic                   in_ready_q;
    logic                   push, pop;
    logic                   main_load, main_clr, main_from_skid;
    logic                   skid_load, skid_clr;
    logic [LANES-1:0]       main_lv, skid_lv, main_lv_d;
    logic [LANES*WIDTH-1:0] main_data, skid_data, main_data_d;

    // An all-empty bundle is accepted but never stored.
    assign push = bus.in_valid && in_ready_q && (|bus.in_lane_valid);
    assign pop  = main_occupied(state_q) && bus.out_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (bus.clear) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d   = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push) begin
                        state_d   = ST_TWO;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_d  = ST_EMPTY;
                        main_clr = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d        = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    assign main_lv_d   = main_from_skid ? skid_lv   : bus.in_lane_valid;
    assign main_data_d = main_from_skid ? skid_data : bus.in_data;

    // in_ready is precomputed from the next state so it never sees out_ready combinationally.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    pipe_skid_entry #(.LANES(LANES), .WIDTH(WIDTH)) u_main (
        .clock        (clock),
        .reset        (reset),
        .clear        (main_clr),
        .load         (main_load),
        .lane_valid_d (main_lv_d),
        .data_d       (main_data_d),
        .lane_valid_q (main_lv),
        .data_q       (main_data)
    );

    pipe_skid_entry #(.LANES(LANES), .WIDTH(WIDTH)) u_skid (
        .clock        (clock),
        .reset        (reset),
        .clear        (skid_clr),
        .load         (skid_load),
        .lane_valid_d (bus.in_lane_valid),
        .data_d       (bus.in_data),
        .lane_valid_q (skid_lv),
        .data_q       (skid_data)
    );

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = main_occupied(state_q);
    assign bus.out_lane_valid = main_lv;
    assign bus.out_data       = main_data;

`ifdef PIPE_SKID_PERF_EN
    logic [STALL_CNT_W-1:0] stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if (main_occupied(state_q) && !bus.out_ready) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_skid_regs.sv
// Randomized and directed bench for pipe_skid_regs against a queue-based bundle model.
// Stall counter checks are included when PIPE_SKID_PERF_EN is defined.
module tb_pipe_skid_regs;

    localparam int LANES = 4;
    localparam int WIDTH = 32;
    localparam int DW    = LANES * WIDTH;

    typedef struct packed {
        logic [LANES-1:0] lv;
        logic [DW-1:0]    d;
    } bundle_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    bundle_t     q[$];
    logic        model_live = 1'b0;
    logic [31:0] exp_stall  = 32'd0;

    pipe_skid_regs_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

`ifdef PIPE_SKID_PERF_EN
    logic [31:0] stall_cycles;
`endif

    pipe_skid_regs #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus.slave)
`ifdef PIPE_SKID_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [LANES-1:0] lv, input logic [DW-1:0] d,
                         input logic ordy, input logic clr);
        bus.in_valid      = v;
        bus.in_lane_valid = lv;
        bus.in_data       = d;
        bus.out_ready     = ordy;
        bus.clear         = clr;
    endtask

    // Reference: a FIFO of at most two bundles, updated from the values seen at each edge.
    always @(posedge clock) begin
        logic do_pop, do_push;
        bundle_t b;
        model_live = 1'b1;
        if (reset) begin
            q.delete();
            exp_stall = 32'd0;
        end else begin
            if (q.size() > 0 && !bus.out_ready) exp_stall = exp_stall + 32'd1;
            if (bus.clear) begin
                q.delete();
            end else begin
                do_pop  = (q.size() > 0) && bus.out_ready;
                do_push = bus.in_valid && (q.size() < 2) && (bus.in_lane_valid != '0);
                b.lv = bus.in_lane_valid;
                b.d  = bus.in_data;
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(b);
            end
        end
    end

    always @(negedge clock) begin
        if (model_live) begin
            check("out_valid", DW'(bus.out_valid), DW'(q.size() > 0));
            check("in_ready", DW'(bus.in_ready), DW'(q.size() < 2));
            if (q.size() > 0) begin
                check("out_lane_valid", DW'(bus.out_lane_valid), DW'(q[0].lv));
                check("out_data", bus.out_data, q[0].d);
            end
`ifdef PIPE_SKID_PERF_EN
            check("stall_cycles", DW'(stall_cycles), DW'(exp_stall));
`endif
        end
    end

    initial begin
        logic [DW-1:0] a_val, b_val, c_val, rnd;
        logic [LANES-1:0] rlv;

        a_val = {4{32'hAAAA_0001}};
        b_val = {4{32'hBBBB_0002}};
        c_val = {4{32'hCCCC_0003}};
        drive(1'b0, '0, '0, 1'b0, 1'b0);

        tick();
        tick();
        check("reset_out_valid", DW'(bus.out_valid), DW'(0));
        check("reset_in_ready", DW'(bus.in_ready), DW'(1));
        check("reset_out_lane_valid", DW'(bus.out_lane_valid), DW'(0));
        check("reset_out_data", bus.out_data, '0);
        reset = 1'b0;

        // Single bundle, one-cycle latency
        drive(1'b1, 4'b1111, a_val, 1'b1, 1'b0);
        tick();
        check("lat_out_valid", DW'(bus.out_valid), DW'(1));
        check("lat_out_data", bus.out_data, a_val);
        check("lat_in_ready", DW'(bus.in_ready), DW'(1));
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        check("lat_drained", DW'(bus.out_valid), DW'(0));

        // Fill both entries with output stalled, then drain in order
        drive(1'b1, 4'b1111, a_val, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'b0101, b_val, 1'b0, 1'b0);
        tick();
        check("two_in_ready", DW'(bus.in_ready), DW'(0));
        check("two_hold_a", bus.out_data, a_val);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        check("two_still_a", bus.out_data, a_val);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        check("drain_b_data", bus.out_data, b_val);
        check("drain_b_lanes", DW'(bus.out_lane_valid), DW'(4'b0101));
        check("drain_in_ready", DW'(bus.in_ready), DW'(1));
        tick();
        check("drain_empty", DW'(bus.out_valid), DW'(0));

        // All-zero lane bundle is swallowed
        drive(1'b1, 4'b0000, c_val, 1'b1, 1'b0);
        tick();
        check("zero_lanes_no_valid", DW'(bus.out_valid), DW'(0));
        check("zero_lanes_in_ready", DW'(bus.in_ready), DW'(1));

        // Clear from TWO discards everything including the offered bundle
        drive(1'b1, 4'b1111, a_val, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'b1111, b_val, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'b1111, c_val, 1'b0, 1'b1);
        tick();
        check("clear_out_valid", DW'(bus.out_valid), DW'(0));
        check("clear_in_ready", DW'(bus.in_ready), DW'(1));
        check("clear_lane_valid", DW'(bus.out_lane_valid), DW'(0));
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clear_c_absent", DW'(bus.out_valid), DW'(0));
        end

        // Full-rate streaming: each accepted index is presented one edge later, no bubbles
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 4'b1111, DW'(i), 1'b1, 1'b0);
            tick();
            check("stream_valid", DW'(bus.out_valid), DW'(1));
            check("stream_data", bus.out_data, DW'(i));
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();

`ifdef PIPE_SKID_PERF_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 4'b1111, a_val, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        check("stall_seven", DW'(stall_cycles), DW'(7));
        drive(1'b0, '0, '0, 1'b1, 1'b1);
        tick();
        check("stall_after_clear", DW'(stall_cycles), DW'(7));
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        check("stall_after_reset", DW'(stall_cycles), DW'(0));
        reset = 1'b0;
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            rlv = ($urandom_range(0, 7) == 0) ? '0 : LANES'($urandom_range(0, 15));
            drive(($urandom_range(0, 3) != 0), rlv, rnd,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 60) == 0));
            reset = ($urandom_range(0, 250) == 0);
            tick();
        end
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        tick();
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
